// File: rtl/branch_pred_queue_pkg.sv
// Shared types for the branch prediction queue: entry layout, pointer/count
// widths and the age helper used for ordering decisions.
package branch_pred_queue_pkg;
  localparam int BPQ_DEPTH = 8;
  localparam int BPQ_TW    = $clog2(BPQ_DEPTH);
  localparam int BPQ_XLEN  = 32;

  typedef logic [BPQ_TW-1:0] ptr_t;
  typedef logic [BPQ_TW:0]   cnt_t;

  typedef struct packed {
    logic                valid;
    logic                resolved;
    logic [BPQ_XLEN-1:0] pc;
    logic [BPQ_XLEN-1:0] pred_pc;
  } entry_t;

  // Distance of tag from head in program order; larger means younger.
  function automatic ptr_t age(input ptr_t tag, input ptr_t head);
    return ptr_t'(tag - head);
  endfunction
endpackage

// File: rtl/branch_pred_queue.sv
// In-order tracker of predicted next PCs between fetch and EX; detects
// mispredicts on (possibly out-of-order) resolution and truncates younger work.
module branch_pred_queue
  import branch_pred_queue_pkg::*;
#(
  parameter int DEPTH = BPQ_DEPTH,
  parameter int TW    = $clog2(DEPTH),
  parameter int XLEN  = BPQ_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alloc_valid,
  output logic            alloc_ready,
  input  logic [XLEN-1:0] alloc_pc,
  input  logic [XLEN-1:0] alloc_pred_pc,
  output logic [TW-1:0]   alloc_tag,
  input  logic            res_valid,
  input  logic [TW-1:0]   res_tag,
  input  logic            res_is_jb,
  input  logic [XLEN-1:0] res_next_pc,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic            btb_upd_valid,
  output logic [XLEN-1:0] btb_upd_pc,
  output logic [XLEN-1:0] btb_upd_target,
  output logic [TW:0]     count
);

  // The entry struct and pointer types are fixed by the package.
  if (DEPTH != BPQ_DEPTH || XLEN != BPQ_XLEN || TW != BPQ_TW) begin : g_param_chk
    $error("branch_pred_queue parameters must match branch_pred_queue_pkg");
  end

  entry_t ents [DEPTH];
  ptr_t   head, tail;
  entry_t hd, re;
  logic   res_hit, res_miss, do_retire, alloc_fire;

  always_comb begin
    hd         = ents[head];
    re         = ents[res_tag];
    res_hit    = res_valid && re.valid && !re.resolved;
    res_miss   = res_hit && (res_next_pc != re.pred_pc);
    do_retire  = hd.valid && hd.resolved;
    alloc_ready = (count != cnt_t'(DEPTH)) && !mispredict;
    // A same-cycle mispredict makes the incoming fetch wrong-path.
    alloc_fire = alloc_valid && alloc_ready && !res_miss;
  end

  assign alloc_tag = tail;

  always_ff @(posedge clk) begin
    if (rst) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      ents           <= '{default: '0};
      mispredict     <= 1'b0;
      redirect_pc    <= '0;
      btb_upd_valid  <= 1'b0;
      btb_upd_pc     <= '0;
      btb_upd_target <= '0;
    end else begin
      mispredict    <= res_miss;
      btb_upd_valid <= res_hit && res_is_jb;
      if (res_miss) redirect_pc <= res_next_pc;
      if (res_hit && res_is_jb) begin
        btb_upd_pc     <= re.pc;
        btb_upd_target <= res_next_pc;
      end

      for (int i = 0; i < DEPTH; i++)
        if (res_miss && age(ptr_t'(i), head) > age(res_tag, head))
          ents[i].valid <= 1'b0;
      if (res_hit) ents[res_tag].resolved <= 1'b1;

      if (alloc_fire)
        ents[tail] <= '{valid: 1'b1, resolved: 1'b0, pc: alloc_pc, pred_pc: alloc_pred_pc};

      if (do_retire) begin
        ents[head].valid <= 1'b0;
        head             <= ptr_t'(head + ptr_t'(1));
      end

      if (res_miss) begin
        tail  <= ptr_t'(res_tag + ptr_t'(1));
        count <= cnt_t'(cnt_t'(age(res_tag, head)) + cnt_t'(1) - cnt_t'(do_retire));
      end else begin
        tail  <= ptr_t'(tail + ptr_t'(alloc_fire));
        count <= cnt_t'(count + cnt_t'(alloc_fire) - cnt_t'(do_retire));
      end
    end
  end

endmodule

// File: tb/tb_branch_pred_queue.sv
// Randomized + directed bench for branch_pred_queue against a program-order
// queue model.
module tb_branch_pred_queue;
  localparam int DEPTH = 8;
  localparam int TW    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          alloc_valid = 1'b0;
  logic          alloc_ready;
  logic [31:0]   alloc_pc = '0, alloc_pred_pc = '0;
  logic [TW-1:0] alloc_tag;
  logic          res_valid = 1'b0;
  logic [TW-1:0] res_tag = '0;
  logic          res_is_jb = 1'b0;
  logic [31:0]   res_next_pc = '0;
  logic          mispredict;
  logic [31:0]   redirect_pc;
  logic          btb_upd_valid;
  logic [31:0]   btb_upd_pc, btb_upd_target;
  logic [TW:0]   count;

  branch_pred_queue dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_pc(alloc_pc), .alloc_pred_pc(alloc_pred_pc), .alloc_tag(alloc_tag),
    .res_valid(res_valid), .res_tag(res_tag), .res_is_jb(res_is_jb),
    .res_next_pc(res_next_pc),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .btb_upd_valid(btb_upd_valid), .btb_upd_pc(btb_upd_pc),
    .btb_upd_target(btb_upd_target), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TW-1:0] tag;
    logic [31:0]   pc;
    logic [31:0]   pred;
    bit            res;
  } rec_t;

  rec_t          mq[$];
  logic [TW-1:0] next_tag;
  bit            exp_mp, exp_bv;
  logic [31:0]   exp_redir, exp_bpc, exp_btgt;
  int            checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("count", 64'(count), 64'(mq.size()));
    chk("alloc_ready", 64'(alloc_ready), 64'((mq.size() < DEPTH) && !exp_mp));
    chk("alloc_tag", 64'(alloc_tag), 64'(next_tag));
    chk("mispredict", 64'(mispredict), 64'(exp_mp));
    if (exp_mp) chk("redirect_pc", 64'(redirect_pc), 64'(exp_redir));
    chk("btb_upd_valid", 64'(btb_upd_valid), 64'(exp_bv));
    if (exp_bv) begin
      chk("btb_upd_pc", 64'(btb_upd_pc), 64'(exp_bpc));
      chk("btb_upd_target", 64'(btb_upd_target), 64'(exp_btgt));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; alloc_valid = 1'b0; res_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    mq.delete(); next_tag = '0; exp_mp = 0; exp_bv = 0;
    check_all();
    chk("rst_redirect_pc", 64'(redirect_pc), 64'd0);
    chk("rst_btb_pc", 64'(btb_upd_pc), 64'd0);
    chk("rst_btb_target", 64'(btb_upd_target), 64'd0);
  endtask

  // One clock: drive inputs, advance the model, compare after the edge.
  task automatic cyc(input logic av, input logic [31:0] apc, input logic [31:0] apred,
                     input logic rv, input logic [TW-1:0] rt, input logic jb,
                     input logic [31:0] npc);
    bit fire, retire, n_mp, n_bv;
    int k;
    alloc_valid = av; alloc_pc = apc; alloc_pred_pc = apred;
    res_valid = rv; res_tag = rt; res_is_jb = jb; res_next_pc = npc;

    fire   = av && (mq.size() < DEPTH) && !exp_mp;
    retire = (mq.size() > 0) && mq[0].res;
    n_mp = 0; n_bv = 0; k = -1;
    if (rv)
      foreach (mq[i]) if (mq[i].tag == rt && !mq[i].res) k = i;
    if (k >= 0) begin
      mq[k].res = 1;
      if (jb) begin n_bv = 1; exp_bpc = mq[k].pc; exp_btgt = npc; end
      if (npc != mq[k].pred) begin
        n_mp = 1; exp_redir = npc;
        while (mq.size() > k + 1) void'(mq.pop_back());
        next_tag = rt + 1'b1;
      end
    end
    if (fire && !n_mp) begin
      mq.push_back('{tag: next_tag, pc: apc, pred: apred, res: 0});
      next_tag = next_tag + 1'b1;
    end
    if (retire) void'(mq.pop_front());
    exp_mp = n_mp; exp_bv = n_bv;

    @(posedge clk); #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    next_tag = '0; exp_mp = 0; exp_bv = 0;
    exp_redir = '0; exp_bpc = '0; exp_btgt = '0;
    do_reset();

    // Correct prediction, retire, drain
    cyc(1, 32'h100, 32'h104, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 32'h104);
    idle(2);

    // Mispredicting jump in the middle of three entries
    do_reset();
    cyc(1, 32'h100, 32'h104, 0, 0, 0, 0);
    cyc(1, 32'h104, 32'h108, 0, 0, 0, 0);
    cyc(1, 32'h108, 32'h10C, 0, 0, 0, 0);
    cyc(1, 32'h10C, 32'h110, 1, 3'd1, 1, 32'h200);
    idle(2);

    // Fill, full backpressure, retire, wrap
    do_reset();
    for (int i = 0; i < DEPTH; i++) cyc(1, 32'h1000 + 32'(i*4), 32'h1004 + 32'(i*4), 0, 0, 0, 0);
    cyc(1, 32'h2000, 32'h2004, 0, 0, 0, 0);
    cyc(1, 32'h2000, 32'h2004, 1, 3'd0, 0, 32'h1004);
    cyc(1, 32'h2000, 32'h2004, 0, 0, 0, 0);
    cyc(1, 32'h2004, 32'h2008, 0, 0, 0, 0);
    cyc(1, 32'h2008, 32'h200C, 0, 0, 0, 0);

    // Younger mispredict, then older one; late resolves ignored
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 32'h40 + 32'(i*4), 32'h44 + 32'(i*4), 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 3'd2, 1, 32'h300);
    cyc(0, 0, 0, 1, 3'd1, 1, 32'h400);
    cyc(0, 0, 0, 1, 3'd2, 1, 32'h4C);
    cyc(0, 0, 0, 1, 3'd3, 1, 32'h999);
    idle(2);

    // Alloc dropped under same-cycle mispredict, then reset mid-queue
    do_reset();
    cyc(1, 32'h500, 32'h504, 0, 0, 0, 0);
    cyc(1, 32'h504, 32'h508, 1, 3'd0, 0, 32'h600);
    cyc(1, 32'h600, 32'h604, 0, 0, 0, 0);
    cyc(1, 32'h604, 32'h608, 1, 3'd1, 1, 32'h700);
    do_reset();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      logic          av, rv, jb;
      logic [31:0]   apc, apred, npc;
      logic [TW-1:0] rt;
      int            k;
      if ($urandom_range(0, 599) == 0) begin do_reset(); continue; end
      av    = ($urandom_range(0, 2) != 0);
      apc   = $urandom & 32'hFFFF_FFFC;
      apred = ($urandom_range(0, 1) == 0) ? apc + 32'd4 : ($urandom & 32'hFFFF_FFFC);
      rv    = ($urandom_range(0, 1) == 0);
      jb    = ($urandom_range(0, 1) == 0);
      rt    = TW'($urandom);
      npc   = $urandom & 32'hFFFF_FFFC;
      if (mq.size() > 0 && $urandom_range(0, 7) != 0) begin
        k  = $urandom_range(0, mq.size() - 1);
        rt = mq[k].tag;
        if ($urandom_range(0, 3) != 0) npc = mq[k].pred;
      end
      cyc(av, apc, apred, rv, rt, jb, npc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
